// File: rtl/spi_flash_read_ctrl.sv
// Single-bit SPI READ sequencer for the N25Q boot flash, returning 32-bit words on a valid/ready stream.
// Optional build macro: SPI_FAST_READ_EN selects FAST READ (0x0B) with 8 dummy clocks after the address.
module spi_flash_read_ctrl #(
  parameter int CLK_DIV = 2,
  parameter int LEN_W   = 12,
  parameter int CS_GAP  = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [23:0]      req_addr,
  input  logic [LEN_W-1:0] req_words,
  output logic             rd_valid,
  output logic [31:0]      rd_data,
  input  logic             rd_ready,
  output logic             busy,
  output logic             done,
  output logic             spi_sclk,
  output logic             spi_cs_n,
  output logic             spi_mosi,
  input  logic             spi_miso,
  output logic             spi_wp_n,
  output logic             spi_hold_n,
  output logic [2:0]       dbg_state
);

  // Handshakes: a transfer happens on a clk edge where valid && ready are both high;
  // valid never drops until that transfer, and data is stable while valid is high.

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);
`ifdef SPI_FAST_READ_EN
  localparam logic [7:0] READ_CMD = 8'h0B;
`else
  localparam logic [7:0] READ_CMD = 8'h03;
`endif

  typedef enum logic [2:0] {
    IDLE, SETUP, CMD, ADDR, DUMMY, DATA, HOLD, GAP
  } state_t;

  state_t           state;
  logic [DW-1:0]    div_cnt;
  logic [GW-1:0]    gap_cnt;
  logic [4:0]       bit_cnt;
  logic [LEN_W-1:0] words_left;
  logic [31:0]      tx_sr;
  logic [31:0]      rx_sr;
  logic             rx_full;

  assign req_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign spi_wp_n   = 1'b1;
  assign spi_hold_n = 1'b1;
  assign dbg_state  = state;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      div_cnt    <= '0;
      gap_cnt    <= '0;
      bit_cnt    <= '0;
      words_left <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      rx_full    <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      done       <= 1'b0;
      spi_sclk   <= 1'b0;
      spi_cs_n   <= 1'b1;
      spi_mosi   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (rd_valid && rd_ready) rd_valid <= 1'b0;
      // A completed word waits in rx_sr until the output register is free.
      if (rx_full && (!rd_valid || rd_ready)) begin
        rd_data  <= rx_sr;
        rd_valid <= 1'b1;
        rx_full  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (req_valid) begin
            tx_sr      <= {READ_CMD, req_addr};
            words_left <= req_words;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            if (req_words == '0) begin
              done    <= 1'b1;
              gap_cnt <= GAP_LAST;
              state   <= GAP;
            end else begin
              spi_cs_n <= 1'b0;
              spi_mosi <= READ_CMD[7];
              state    <= SETUP;
            end
          end
        end

        SETUP: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            spi_sclk <= 1'b1;
            state    <= CMD;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        CMD, ADDR, DUMMY, DATA: begin
          if (!spi_sclk) begin
            // Low phase; in DATA the next rise is withheld while a word is stuck in rx_sr.
            if (div_cnt != DIV_LAST) begin
              div_cnt <= div_cnt + 1'b1;
            end else if (!(state == DATA && rx_full)) begin
              spi_sclk <= 1'b1;
              div_cnt  <= '0;
              if (state == DATA) begin
                rx_sr <= {rx_sr[30:0], spi_miso};
                if (bit_cnt == 5'd31) rx_full <= 1'b1;
              end
            end
          end else if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            spi_sclk <= 1'b0;
            div_cnt  <= '0;
            tx_sr    <= {tx_sr[30:0], 1'b0};
            spi_mosi <= tx_sr[30];
            bit_cnt  <= bit_cnt + 1'b1;
            if (state == CMD && bit_cnt == 5'd7) begin
              bit_cnt <= '0;
              state   <= ADDR;
            end else if (state == ADDR && bit_cnt == 5'd23) begin
              bit_cnt <= '0;
`ifdef SPI_FAST_READ_EN
              state   <= DUMMY;
`else
              state   <= DATA;
`endif
            end else if (state == DUMMY && bit_cnt == 5'd7) begin
              bit_cnt <= '0;
              state   <= DATA;
            end else if (state == DATA && bit_cnt == 5'd31) begin
              if (words_left == LEN_W'(1)) state <= HOLD;
              else words_left <= words_left - 1'b1;
            end
          end
        end

        HOLD: begin
          if (!rx_full) begin
            if (div_cnt == DIV_LAST) begin
              spi_cs_n <= 1'b1;
              done     <= 1'b1;
              gap_cnt  <= '0;
              state    <= GAP;
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
        end

        GAP: begin
          if (gap_cnt == GAP_LAST) state <= IDLE;
          else gap_cnt <= gap_cnt + 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_read_ctrl.sv
// Directed bench for spi_flash_read_ctrl with a behavioural SPI flash model on DQ0/DQ1.
module tb_spi_flash_read_ctrl;

  localparam int CLK_DIV = 2;
  localparam int LEN_W   = 12;
  localparam int CS_GAP  = 4;
`ifdef SPI_FAST_READ_EN
  localparam int HDR = 40;
  localparam logic [7:0] EXP_CMD = 8'h0B;
`else
  localparam int HDR = 32;
  localparam logic [7:0] EXP_CMD = 8'h03;
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [23:0]      req_addr = '0;
  logic [LEN_W-1:0] req_words = '0;
  logic             rd_valid;
  logic [31:0]      rd_data;
  logic             rd_ready = 1'b0;
  logic             busy, done;
  logic             spi_sclk, spi_cs_n, spi_mosi;
  logic             spi_miso = 1'b0;
  logic             spi_wp_n, spi_hold_n;
  logic [2:0]       dbg_state;

  spi_flash_read_ctrl #(.CLK_DIV(CLK_DIV), .LEN_W(LEN_W), .CS_GAP(CS_GAP)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_words(req_words),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
    .busy(busy), .done(done),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .spi_wp_n(spi_wp_n), .spi_hold_n(spi_hold_n), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // flash model: header captured on SCLK rise, data driven on SCLK fall
  logic [7:0]  mem [0:255];
  logic [31:0] hdr_sr = '0;
  int          rise_n = 0;
  int          rises_total = 0;
  int          cs_falls = 0;

  always @(negedge spi_cs_n or posedge spi_sclk) begin
    if (spi_sclk) begin
      if (!spi_cs_n) begin
        if (rise_n < 32) hdr_sr = {hdr_sr[30:0], spi_mosi};
        rise_n++;
        rises_total++;
      end
    end else begin
      rise_n = 0;
      cs_falls++;
    end
  end

  always @(negedge spi_sclk) begin
    int d;
    logic [7:0] idx, b;
    if (!spi_cs_n && rise_n >= HDR) begin
      d   = rise_n - HDR;
      idx = hdr_sr[7:0] + 8'(d / 8);
      b   = mem[idx];
      spi_miso = b[3'd7 - 3'(d % 8)];
    end
  end

  // scoreboard
  logic [31:0] exp_q[$];
  int total = 0;
  int bad = 0;

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [23:0] a, input int w);
    logic [7:0] base;
    base = a[7:0] + 8'(4 * w);
    return {mem[base], mem[base + 8'd1], mem[base + 8'd2], mem[base + 8'd3]};
  endfunction

  typedef struct {
    logic [23:0] addr;
    int          words;
    int          bp;      // cycles rd_ready stays low after the first rd_valid
    bit          timing;  // check exact first-word latency
    logic [31:0] exp0;    // hand-computed first word
  } vec_t;

  task automatic run_txn(input vec_t v);
    int k, first_valid, done_k, done_cnt, ready_k, r0, f0, r_mid;
    bit finished;
    r0 = rises_total;
    f0 = cs_falls;
    for (int w = 0; w < v.words; w++)
      exp_q.push_back(w == 0 ? v.exp0 : model_word(v.addr, w));
    @(negedge clk);
    check_bit("req_ready_before", req_ready, 1'b1);
    req_valid = 1'b1;
    req_addr  = v.addr;
    req_words = LEN_W'(v.words);
    rd_ready  = (v.bp == 0);
    first_valid = -1; done_k = -1; done_cnt = 0; ready_k = -1; r_mid = -1;
    k = 0;
    finished = 1'b0;
    while (!finished && k < 20000) begin
      @(negedge clk);
      k++;
      req_valid = 1'b0;
      if (k == 1) begin
        check_bit("cs_n_at_t1", spi_cs_n, v.words == 0);
        check_bit("req_ready_at_t1", req_ready, 1'b0);
        check_bit("done_at_t1", done, v.words == 0);
      end
      if (done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (rd_valid && first_valid < 0) first_valid = k;
      if (v.bp > 0 && first_valid >= 0) rd_ready = (k >= first_valid + v.bp);
      if (v.bp >= 200 && first_valid >= 0 && k == first_valid + 150) begin
        r_mid = rises_total - r0;
        check_val("rises_at_stall", r_mid, HDR + 64);
      end
      if (v.bp >= 200 && first_valid >= 0 && k == first_valid + 199)
        check_val("sclk_frozen", rises_total - r0, r_mid);
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) check_val("unexpected_word", rd_data, 32'hx);
        else check_val("rd_data", rd_data, exp_q.pop_front());
      end
      if (done_k >= 0 && req_ready && ready_k < 0) ready_k = k;
      if (ready_k >= 0 && exp_q.size() == 0) finished = 1'b1;
    end
    if (!finished) begin
      total++;
      bad++;
      $display("FAIL txn_timeout: got %0d words left want 0", exp_q.size());
      exp_q.delete();
    end
    rd_ready = 1'b0;
    check_val("done_count", done_cnt, 1);
    check_val("gap_cycles", ready_k - done_k, v.words == 0 ? 1 : CS_GAP);
    check_val("sclk_rises", rises_total - r0, v.words == 0 ? 0 : HDR + 32 * v.words);
    check_val("cs_falls", cs_falls - f0, v.words == 0 ? 0 : 1);
    if (v.words != 0) begin
      check_val("cmd_byte", hdr_sr[31:24], EXP_CMD);
      check_val("addr", hdr_sr[23:0], v.addr);
      if (v.bp < 100) check_val("done_cycle", done_k, 4 * (HDR + 32 * v.words) + 3);
    end
    if (v.timing) check_val("first_valid_cycle", first_valid, 4 * HDR + 128);
  endtask

  task automatic reset_checks(input string tag);
    check_bit({tag, "_cs_n"}, spi_cs_n, 1'b1);
    check_bit({tag, "_sclk"}, spi_sclk, 1'b0);
    check_bit({tag, "_mosi"}, spi_mosi, 1'b0);
    check_bit({tag, "_req_ready"}, req_ready, 1'b1);
    check_bit({tag, "_rd_valid"}, rd_valid, 1'b0);
    check_bit({tag, "_busy"}, busy, 1'b0);
    check_bit({tag, "_done"}, done, 1'b0);
    check_val({tag, "_rd_data"}, rd_data, 32'h0);
    check_val({tag, "_state"}, dbg_state, 3'd0);
  endtask

  vec_t vecs[5];

  initial begin
    int k, pops, kill_k;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
    mem[8'h10] = 8'hDE; mem[8'h11] = 8'hAD; mem[8'h12] = 8'hBE; mem[8'h13] = 8'hEF;

    vecs[0] = '{addr: 24'h000010, words: 1, bp: 0,   timing: 1'b1, exp0: 32'hDEADBEEF};
    vecs[1] = '{addr: 24'h000020, words: 4, bp: 200, timing: 1'b0, exp0: 32'h85848786};
    vecs[2] = '{addr: 24'h000040, words: 3, bp: 0,   timing: 1'b0, exp0: 32'hE5E4E7E6};
    vecs[3] = '{addr: 24'h000000, words: 0, bp: 0,   timing: 1'b0, exp0: 32'h0};
    vecs[4] = '{addr: 24'h0000F0, words: 2, bp: 3,   timing: 1'b0, exp0: 32'h55545756};

    // reset held for 5 cycles
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset_checks("reset");
    check_bit("wp_n", spi_wp_n, 1'b1);
    check_bit("hold_n", spi_hold_n, 1'b1);
    reset_n = 1'b1;

    foreach (vecs[i]) run_txn(vecs[i]);

    // reset in the middle of a 16-word burst, during word 3
    for (int w = 0; w < 2; w++) exp_q.push_back(model_word(24'h000080, w));
    @(negedge clk);
    req_valid = 1'b1; req_addr = 24'h000080; req_words = LEN_W'(16); rd_ready = 1'b1;
    pops = 0; kill_k = -1; k = 0;
    while (kill_k < 0 && k < 3000) begin
      @(negedge clk);
      k++;
      req_valid = 1'b0;
      if (rd_valid && rd_ready) begin
        pops++;
        if (exp_q.size() != 0) check_val("burst_word", rd_data, exp_q.pop_front());
      end
      if (pops == 2 && exp_q.size() == 0 && k > 0) begin
        repeat (40) @(negedge clk);
        kill_k = k;
      end
    end
    if (kill_k < 0) begin
      total++;
      bad++;
      $display("FAIL burst_timeout: got %0d words want 2", pops);
    end
    check_bit("burst_cs_active", spi_cs_n, 1'b0);
    reset_n = 1'b0;
    @(negedge clk);
    reset_checks("midreset");
    repeat (3) begin
      @(negedge clk);
      check_bit("midreset_no_done", done, 1'b0);
    end
    reset_n = 1'b1;
    rd_ready = 1'b0;
    run_txn('{addr: 24'h000000, words: 2, bp: 0, timing: 1'b1, exp0: 32'hA5A4A7A6});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
